// File: rtl/soc_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// soc_bus_arbiter_if : master-side and decoder-side signals of the bus arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface soc_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS-1:0]        m_wr_en;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [DATA_W-1:0]             m_rdata;
  logic                          s_valid;
  logic [ADDR_W-1:0]             s_addr;
  logic                          s_wr_en;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic [1:0]                    arb_owner;
  logic                          arb_preempt;

  // Arbiter view
  modport slave (
    input  m_req, m_addr, m_wr_en, m_wdata, s_rdata,
    output m_gnt, m_rdata, s_valid, s_addr, s_wr_en, s_wdata, arb_owner, arb_preempt
  );

  // Bus masters and decoder view
  modport master (
    output m_req, m_addr, m_wr_en, m_wdata, s_rdata,
    input  m_gnt, m_rdata, s_valid, s_addr, s_wr_en, s_wdata, arb_owner, arb_preempt
  );
endinterface

`default_nettype wire

// File: rtl/soc_bus_arbiter.sv
//------------------------------------------------------------------------------
// soc_bus_arbiter : round-robin arbiter for the shared SoC bus, registered grant.
// Optional hold-limit preemption enabled by defining ARB_HOLD_LIMIT_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module soc_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  soc_bus_arbiter_if.slave  bus
);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
      $error("soc_bus_arbiter: NUM_MASTERS must be in 2..4");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("soc_bus_arbiter: MAX_HOLD must be >= 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_gnt, w_gnt_nxt;
  logic [1:0]             r_owner, w_owner_nxt;
  logic [1:0]             r_last, w_last_nxt;

  logic [3:0]             w_req4;
  logic [1:0]             w_winner;
  logic                   w_found;
  logic                   w_owner_req;
  logic                   w_valid;

  // Requests widened to four so owner-indexed lookups never go out of range
  always_comb begin
    w_req4 = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req4[i] = bus.m_req[i];
    end
  end

  assign w_owner_req = w_req4[r_owner];

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!w_found && w_req4[(int'(r_last) + k) % NUM_MASTERS]) begin
        w_found  = 1'b1;
        w_winner = 2'((int'(r_last) + k) % NUM_MASTERS);
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int c_hold_w = $clog2(MAX_HOLD + 1);

  logic [c_hold_w-1:0] r_hold, w_hold_nxt;
  logic                r_preempt, w_preempt_nxt;
  logic                w_others;

  assign w_others = |(w_req4 & ~(4'b0001 << r_owner));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
`ifdef ARB_HOLD_LIMIT_EN
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_winner;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            w_gnt_nxt[i] = (i == int'(w_winner));
          end
`ifdef ARB_HOLD_LIMIT_EN
          w_hold_nxt = '0;
`endif
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_owner;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (r_hold == c_hold_w'(MAX_HOLD - 1) && w_others) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          w_last_nxt    = r_owner;
          w_preempt_nxt = 1'b1;
        end else if (r_hold != c_hold_w'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + c_hold_w'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= 2'(NUM_MASTERS - 1);
`ifdef ARB_HOLD_LIMIT_EN
      r_hold    <= '0;
      r_preempt <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
`ifdef ARB_HOLD_LIMIT_EN
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
`endif
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  assign bus.arb_preempt = r_preempt;
`else
  assign bus.arb_preempt = 1'b0;
`endif

  // An owner that already dropped its request gets no bus cycle in its last granted cycle
  assign w_valid = (|r_gnt) & w_owner_req;

  always_comb begin
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wr_en = 1'b0;
    if (w_valid) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (int'(r_owner) == i) begin
          bus.s_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
          bus.s_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
          bus.s_wr_en = bus.m_wr_en[i];
        end
      end
    end
  end

  assign bus.s_valid   = w_valid;
  assign bus.m_gnt     = r_gnt;
  assign bus.arb_owner = r_owner;
  assign bus.m_rdata   = bus.s_rdata;

endmodule

`default_nettype wire

// File: tb/tb_soc_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_soc_bus_arbiter : directed self-checking bench for soc_bus_arbiter
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_soc_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_bus_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  soc_bus_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int dma_cycles, preempt_cnt, cpu_k;
  bit cpu_seen;
  int exp_dma, exp_pre, exp_cpu_k;

  initial begin
    bus.m_req   = '0;
    bus.m_addr  = {32'h0002_0000, 32'h0001_0000};
    bus.m_wdata = {32'h0000_6000, 32'h0000_5000};
    bus.m_wr_en = 2'b11;
    bus.s_rdata = '0;
    repeat (2) tick;

    check("rst_gnt", 64'(bus.m_gnt), 64'h0);
    check("rst_valid", 64'(bus.s_valid), 64'h0);
    check("rst_addr", 64'(bus.s_addr), 64'h0);
    check("rst_wdata", 64'(bus.s_wdata), 64'h0);
    check("rst_wr_en", 64'(bus.s_wr_en), 64'h0);
    check("rst_preempt", 64'(bus.arb_preempt), 64'h0);
    check("rst_owner", 64'(bus.arb_owner), 64'h0);
    bus.s_rdata = 32'h0BAD_DDAA;
    #1;
    check("rdata_no_owner", 64'(bus.m_rdata), 64'h0BAD_DDAA);

    rst_n = 1'b1;
    tick;
    check("idle_gnt", 64'(bus.m_gnt), 64'h0);

    // Single CPU write
    bus.m_req = 2'b01;
    tick;
    check("cpu_gnt", 64'(bus.m_gnt), 64'h1);
    check("cpu_owner", 64'(bus.arb_owner), 64'h0);
    check("cpu_valid", 64'(bus.s_valid), 64'h1);
    check("cpu_addr", 64'(bus.s_addr), 64'h0001_0000);
    check("cpu_wdata", 64'(bus.s_wdata), 64'h5000);
    check("cpu_wr_en", 64'(bus.s_wr_en), 64'h1);
    bus.m_req = 2'b00;
    tick;
    check("cpu_release_gnt", 64'(bus.m_gnt), 64'h0);
    check("cpu_release_addr", 64'(bus.s_addr), 64'h0);

    // Simultaneous requests right after reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.m_req = 2'b11;
    tick;
    check("rr0_gnt", 64'(bus.m_gnt), 64'h1);
    bus.m_req = 2'b10;
    #1;
    check("drop_valid", 64'(bus.s_valid), 64'h0);
    check("drop_wr_en", 64'(bus.s_wr_en), 64'h0);
    tick;
    check("dead_cycle_gnt", 64'(bus.m_gnt), 64'h0);
    tick;
    check("dma_gnt", 64'(bus.m_gnt), 64'h2);
    check("dma_owner", 64'(bus.arb_owner), 64'h1);
    check("dma_addr", 64'(bus.s_addr), 64'h0002_0000);
    check("dma_wdata", 64'(bus.s_wdata), 64'h6000);
    bus.m_req = 2'b00;
    tick;
    check("dma_release_gnt", 64'(bus.m_gnt), 64'h0);
    bus.m_req = 2'b11;
    tick;
    check("rr1_gnt", 64'(bus.m_gnt), 64'h1);
    bus.m_req = 2'b00;
    repeat (2) tick;

    // DMA streams for 40 cycles while the CPU asks from cycle 4
    dma_cycles  = 0;
    preempt_cnt = 0;
    cpu_k       = -1;
    cpu_seen    = 1'b0;
    bus.m_req   = 2'b10;
    tick;
    for (int k = 0; k < 50; k++) begin
      if (bus.m_gnt == 2'b01 && !cpu_seen) begin
        cpu_seen = 1'b1;
        cpu_k    = k;
      end
      if (bus.m_gnt == 2'b10 && !cpu_seen) dma_cycles++;
      if (bus.arb_preempt) preempt_cnt++;
      bus.m_req[1] = (k + 1 < 40);
      bus.m_req[0] = (k + 1 >= 4) && !cpu_seen;
      tick;
    end
`ifdef ARB_HOLD_LIMIT_EN
    exp_dma = 16; exp_pre = 1; exp_cpu_k = 17;
`else
    exp_dma = 40; exp_pre = 0; exp_cpu_k = 41;
`endif
    check("hold_dma_cycles", 64'(dma_cycles), 64'(exp_dma));
    check("hold_preempt_cnt", 64'(preempt_cnt), 64'(exp_pre));
    check("hold_cpu_grant_k", 64'(cpu_k), 64'(exp_cpu_k));

    // Asynchronous reset in the middle of a DMA write
    bus.m_req = 2'b10;
    tick;
    check("pre_rst_gnt", 64'(bus.m_gnt), 64'h2);
    check("pre_rst_wr_en", 64'(bus.s_wr_en), 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 64'(bus.m_gnt), 64'h0);
    check("async_rst_valid", 64'(bus.s_valid), 64'h0);
    check("async_rst_wr_en", 64'(bus.s_wr_en), 64'h0);
    check("async_rst_addr", 64'(bus.s_addr), 64'h0);
    tick;
    rst_n = 1'b1;
    bus.m_req = 2'b11;
    tick;
    check("post_rst_gnt", 64'(bus.m_gnt), 64'h1);
    bus.m_req = 2'b00;
    tick;
    check("end_gnt", 64'(bus.m_gnt), 64'h0);
    check("end_valid", 64'(bus.s_valid), 64'h0);
    check("end_rdata", 64'(bus.m_rdata), 64'h0BAD_DDAA);
    bus.s_rdata = 32'h1234_5678;
    #1;
    check("rdata_follow", 64'(bus.m_rdata), 64'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/soc_bus_arbiter.md
# soc_bus_arbiter

Round-robin arbiter that shares the single SoC system bus between up to four masters: CPU, DMA and future masters such as a CRC streaming engine. It sits between the master ports and the address decoder. It registers grants and multiplexes the owner's address, write-enable and write data onto the slave side. An optional hold-limit preempts a master that monopolises the bus while others wait.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters (2..4); index 0 = CPU, 1 = DMA
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_HOLD, 16, maximum consecutive granted cycles before preemption (≥2; used only with ARB_HOLD_LIMIT_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master bus request, level
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address; master i occupies slice [i*ADDR_W +: ADDR_W]
- m_wr_en  in  NUM_MASTERS  per-master write enable
- m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
- m_gnt  out  NUM_MASTERS  registered one-hot grant
- m_rdata  out  DATA_W  read data broadcast to all masters (= s_rdata)
- s_valid  out  1  bus cycle valid toward decoder
- s_addr  out  ADDR_W  owner's address
- s_wr_en  out  1  owner's write enable, gated by s_valid
- s_wdata  out  DATA_W  owner's write data
- s_rdata  in  DATA_W  read data from decoder mux
- arb_owner  out  2  index of current owner (valid when any m_gnt bit is set)
- arb_preempt  out  1  one-cycle pulse when a hold-limit preemption occurs

## Operation
- States: IDLE, GRANT. Registers: state, m_gnt, owner, last_owner (round-robin pointer), hold_cnt ($clog2(MAX_HOLD+1) bits).
- IDLE: if any m_req is set, pick the first requester scanning last_owner+1, last_owner+2, … modulo NUM_MASTERS. Then set m_gnt[winner], owner = winner, hold_cnt = 0, and go to GRANT. If no request, stay in IDLE.
- GRANT, owner's m_req low: clear m_gnt, last_owner = owner, go to IDLE. This yields one dead cycle between owners; back-to-back re-grant to the same master is also through IDLE.
- GRANT, owner's m_req high: hold_cnt increments, saturating at MAX_HOLD.
- s_valid = |m_gnt & m_req[owner]. The owner dropping req in the cycle before its grant falls does not produce a bus cycle.
- When s_valid = 0: s_addr = 0, s_wdata = 0, s_wr_en = 0. Otherwise these pass through combinationally from the owner's slice.
- m_rdata = s_rdata combinationally, unconditionally.
- Requests from non-owners while in GRANT are ignored until the next IDLE.
- Requests for indices ≥ NUM_MASTERS do not exist; a NUM_MASTERS value outside 2..4 is a synthesis error (generate-time check).

## Timing
- Reset values: state = IDLE, m_gnt = 0, owner = 0, last_owner = NUM_MASTERS-1 (so master 0 wins first), hold_cnt = 0, arb_preempt = 0, s_valid = 0, s_addr = 0, s_wdata = 0, s_wr_en = 0. m_rdata follows s_rdata.
- Grant latency: req sampled high at edge N in IDLE → m_gnt high after edge N (visible in cycle N..N+1); the first s_valid is in that cycle.
- Release: owner req sampled low at edge K → m_gnt low after K. The earliest next grant is after K+1.
- Simultaneous requests in IDLE: round-robin order only; there is no fixed priority.
- Reset asserted mid-GRANT: all outputs go to reset values immediately (asynchronous); the in-flight write is dropped.
- hold_cnt wrap: it saturates and never wraps.

## Configuration
- ARB_HOLD_LIMIT_EN defined: in GRANT, if hold_cnt == MAX_HOLD-1 and any other master requests at that edge, clear m_gnt, set last_owner = owner, pulse arb_preempt for one cycle, and go to IDLE. The preempted master keeps its req and re-competes in round-robin order.
- ARB_HOLD_LIMIT_EN undefined: the owner holds the bus until it drops req. hold_cnt logic is removed, and arb_preempt is tied to 0.

## Test plan
- Reset, then CPU raises req at cycle 3 → m_gnt = 2'b01 after the next edge. s_addr and s_wdata equal the CPU slice (0x0001_0000 / 0x5000), and s_wr_en = 1.
- CPU and DMA raise req on the same edge after reset → CPU granted first. When the CPU drops req, there is one dead cycle, then DMA is granted. Next simultaneous request → DMA has just owned, so CPU wins.
- DMA holds req for 40 cycles while the CPU requests at cycle 5, with ARB_HOLD_LIMIT_EN defined and MAX_HOLD = 16 → DMA preempted after 16 granted cycles, arb_preempt pulses once, and the CPU is granted 2 edges later.
- Same stimulus without ARB_HOLD_LIMIT_EN → DMA holds for all 40 cycles, arb_preempt stays 0, and the CPU is granted only after DMA releases.
- Assert rst_n low mid-write during a DMA grant → m_gnt = 0, s_valid = 0, s_wr_en = 0 with no clock edge. After release, the first grant goes to master 0.
- Drive s_rdata = 0xBADDDAA with no owner → m_rdata = 0xBADDDAA and s_valid = 0.
